// File: rtl/base_digit_encoder_pkg.sv
// Shared definitions for the base digit encoder: base select codes, per-base
// digit limits and the entry FSM state type.
package base_digit_encoder_pkg;

  localparam logic [1:0] SEL_INV = 2'b00;
  localparam logic [1:0] SEL_HEX = 2'b01;
  localparam logic [1:0] SEL_OCT = 2'b10;
  localparam logic [1:0] SEL_DEC = 2'b11;

  localparam logic [1:0] MAX_DIG_DEC = 2'd3;
  localparam logic [1:0] MAX_DIG_HEX = 2'd2;
  localparam logic [1:0] MAX_DIG_OCT = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    ERROR = 2'd3
  } state_e;

  // A base of zero marks an invalid select; base_mac rejects every digit then.
  function automatic logic [4:0] base_of(input logic [1:0] sel);
    case (sel)
      SEL_DEC: return 5'd10;
      SEL_HEX: return 5'd16;
      SEL_OCT: return 5'd8;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] max_digits(input logic [1:0] sel);
    case (sel)
      SEL_DEC: return MAX_DIG_DEC;
      SEL_HEX: return MAX_DIG_HEX;
      SEL_OCT: return MAX_DIG_OCT;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/base_mac.sv
// Combinational multiply-accumulate for digit entry: acc*base + digit, with an
// 8-bit range check and a digit-versus-base validity check.
module base_mac (
  input  logic [7:0] acc,
  input  logic [3:0] digit,
  input  logic [4:0] base,
  output logic [7:0] next_acc,
  output logic       ovf,
  output logic       bad_digit
);

  logic [12:0] product;

  // 255*16 + 15 fits in 13 bits, so the upper bits are an exact overflow test.
  always_comb begin
    product   = 13'(acc) * 13'(base) + 13'(digit);
    next_acc  = product[7:0];
    ovf       = |product[12:8];
    bad_digit = (base == 5'd0) || ({1'b0, digit} >= base);
  end

endmodule

// File: rtl/base_digit_encoder.sv
// Keypad digit accumulator for decimal/hex/octal operands with commit, clear,
// overflow trapping and optional backspace (enabled by defining BACKSPACE_EN).
module base_digit_encoder
  import base_digit_encoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sel,
  input  logic [3:0] digit_in,
  input  logic       digit_strobe,
  input  logic       commit,
  input  logic       clear,
  input  logic       backspace,
  output logic [7:0] acc,
  output logic [7:0] value,
  output logic       valid,
  output logic [1:0] digit_count,
  output logic       overflow,
  output logic       err_digit
);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] value_q, value_d;
  logic [1:0] count_q, count_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;
  logic       err_q, err_d;

  logic [4:0] base;
  logic [1:0] max_cnt;
  logic [7:0] mac_acc;
  logic       mac_ovf;
  logic       mac_bad;
  logic       in_entry;

  assign base    = base_of(sel);
  assign max_cnt = max_digits(sel);

  base_mac u_mac (
    .acc       (acc_q),
    .digit     (digit_in),
    .base      (base),
    .next_acc  (mac_acc),
    .ovf       (mac_ovf),
    .bad_digit (mac_bad)
  );

`ifndef BACKSPACE_EN
  logic unused_backspace;
  assign unused_backspace = backspace;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    value_d    = value_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    sel_d      = sel;
    in_entry   = (state_q == ENTRY) || (state_q == FULL);

    // Each branch consumes the cycle: lower-priority events are dropped.
    if (clear || (in_entry && (sel != sel_q))) begin
      state_d    = EMPTY;
      acc_d      = 8'd0;
      count_d    = 2'd0;
      overflow_d = 1'b0;
    end else if (commit) begin
      if (in_entry) begin
        value_d = acc_q;
        valid_d = 1'b1;
        acc_d   = 8'd0;
        count_d = 2'd0;
        state_d = EMPTY;
      end
`ifdef BACKSPACE_EN
    end else if (backspace) begin
      if (in_entry) begin
        acc_d   = acc_q / {3'b000, base};
        count_d = count_q - 2'd1;
        state_d = (count_q == 2'd1) ? EMPTY : ENTRY;
      end
`endif
    end else if (digit_strobe && (state_q != ERROR)) begin
      if ((state_q == FULL) || mac_bad) begin
        err_d = 1'b1;
      end else if (mac_ovf) begin
        state_d    = ERROR;
        overflow_d = 1'b1;
      end else begin
        acc_d   = mac_acc;
        count_d = count_q + 2'd1;
        state_d = ((count_q + 2'd1) == max_cnt) ? FULL : ENTRY;
      end
    end
  end

  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    if (reset) begin
      state_q    <= EMPTY;
      acc_q      <= 8'd0;
      value_q    <= 8'd0;
      count_q    <= 2'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      value_q    <= value_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  assign acc         = acc_q;
  assign value       = value_q;
  assign valid       = valid_q;
  assign digit_count = count_q;
  assign overflow    = overflow_q;
  assign err_digit   = err_q;

endmodule
